updown_step_counter: RTL and testbench
======================================

Name: updown_step_counter

Overview:
- Parametrised up/down counter; next generation of the basic increment/decrement pointer.
- Adds programmable modulus, variable step size and wrap or saturate mode.
- Adds synchronous clear, parallel load, terminal decodes and registered overflow/underflow pulses.
- Used for FIFO occupancy, credit counters and decade/modulo timers in the BasicSynchronousLogic library.

Parameters:
- WIDTH, 6: count register width in bits.
- MAX_COUNT, 2**WIDTH-1: terminal value; modulus is MAX_COUNT+1. Legal range 1 .. 2**WIDTH-1.
- STEP_WIDTH, 1: width of the step input. Requires 2**STEP_WIDTH-1 <= MAX_COUNT+1.
- MODE, COUNT_WRAP: counter_mode_e. COUNT_WRAP is modulo arithmetic; COUNT_SATURATE clamps at 0 and MAX_COUNT.
- Elaboration: illegal parameter combinations stop elaboration via $fatal.

Ports:
- clock  input  1  core clock, rising edge.
- reset  input  1  asynchronous reset, active-high.
- clear  input  1  synchronous clear to 0.
- load  input  1  synchronous parallel load.
- load_value  input  WIDTH  value for load.
- increment  input  1  count up by step.
- decrement  input  1  count down by step.
- step  input  STEP_WIDTH  magnitude of the change; unsigned.
- count  output  WIDTH  current count (registered).
- is_zero  output  1  count == 0 (combinational decode of registered count).
- is_max  output  1  count == MAX_COUNT (combinational decode of registered count).
- overflow  output  1  one-cycle registered pulse: an up-count crossed MAX_COUNT.
- underflow  output  1  one-cycle registered pulse: a down-count crossed 0.

Behaviour:
- Reset is asynchronous, active-high. While reset is asserted: count=0, overflow=0, underflow=0, is_zero=1, is_max=0.
- Priority on each rising clock edge: reset > clear > load > (increment XOR decrement) > hold.
- clear: count<=0; both pulses 0.
- load: count<=min(load_value, MAX_COUNT); both pulses 0.
- Hold cases, with pulses 0:
  - increment and decrement both high.
  - Neither increment nor decrement high.
  - step==0 with increment or decrement high.
- Arithmetic: computed at WIDTH+1 bits, unsigned. Define sum=count+step; a down-count underflows when step>count.
- Up, COUNT_WRAP:
  - sum<=MAX_COUNT: count<=sum, overflow<=0.
  - Otherwise: count<=sum-(MAX_COUNT+1), overflow<=1.
- Up, COUNT_SATURATE:
  - sum<=MAX_COUNT: count<=sum.
  - Otherwise: count<=MAX_COUNT, overflow<=1. This includes attempts made while already at MAX_COUNT.
- Down, COUNT_WRAP:
  - step<=count: count<=count-step.
  - Otherwise: count<=count+(MAX_COUNT+1)-step, underflow<=1.
- Down, COUNT_SATURATE:
  - step<=count: count<=count-step.
  - Otherwise: count<=0, underflow<=1. This includes attempts made while already at 0.
- Latency:
  - count and the pulses update on the same edge that samples the request.
  - The pulses are visible for exactly the following cycle, then return to 0 unless re-triggered.
  - is_zero and is_max follow count with zero added latency.
- Non-power-of-two MAX_COUNT: count never holds a value above MAX_COUNT.
- Reset asserted mid-operation clears count and both pulses immediately, independent of clock. No pending state survives.
- No X propagation: with inputs at known values, every output is known after reset.

Decomposition:
- Shared package counter_pkg:
  - typedef enum logic {COUNT_WRAP, COUNT_SATURATE} counter_mode_e.
  - Function clamp_to_max(value, max) reused by the load path.
- One combinational sub-module, counter_next_value:
  - Inputs: count, step, direction, MODE, MAX_COUNT.
  - Outputs: next count plus overflow/underflow strobes.
- Top level holds the priority mux and registers. The sub-module is reusable by pointer and credit blocks.

Test Plan:
- Config for scenarios 1-5: WIDTH=4, MAX_COUNT=9, STEP_WIDTH=2, MODE=COUNT_WRAP.
1. Reset pulse mid-cycle at count=7 -> count=0, is_zero=1, overflow=underflow=0 before the next clock edge.
2. From 8, increment with step=3 -> count=1, overflow=1 for one cycle. Next cycle, increment step=1 -> count=2, overflow=0.
3. From 1, decrement with step=2 -> count=9, underflow=1, is_max=1.
4. increment=decrement=1 with step=3 at count=5 -> count stays 5, no pulses. Same stimulus with step=0 -> also holds.
5. load=1, load_value=14, with clear=0 and increment=1 -> count=9. Then clear=1 with load=1 -> count=0.
6. Config as above with MODE=COUNT_SATURATE. From 8, increment step=3 -> count=9, overflow=1. Again -> 9, overflow=1. From 1, decrement step=3 -> 0, underflow=1.

Source files
------------

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and helpers for the up/down step counter family
package counter_pkg;

    typedef enum logic {COUNT_WRAP, COUNT_SATURATE} counter_mode_e;
    typedef enum logic {DIR_UP, DIR_DOWN} count_dir_e;

    // Limits a requested value to the counter's terminal value.
    function automatic int unsigned clamp_to_max(input int unsigned value,
                                                 input int unsigned max_value);
        return (value > max_value) ? max_value : value;
    endfunction

endpackage

// File: rtl/updown_step_counter_if.sv
// rtl/updown_step_counter_if.sv - control/status bundle of the up/down step counter
//
// Ports (master drives controls, slave returns status):
//   clear, load, load_value, increment, decrement, step : controls
//   count, is_zero, is_max, overflow, underflow          : status
interface updown_step_counter_if #(
    parameter int WIDTH      = 6,
    parameter int STEP_WIDTH = 1
);
    logic                  clear;
    logic                  load;
    logic [WIDTH-1:0]      load_value;
    logic                  increment;
    logic                  decrement;
    logic [STEP_WIDTH-1:0] step;
    logic [WIDTH-1:0]      count;
    logic                  is_zero;
    logic                  is_max;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output clear, load, load_value, increment, decrement, step,
        input  count, is_zero, is_max, overflow, underflow
    );

    modport slave (
        input  clear, load, load_value, increment, decrement, step,
        output count, is_zero, is_max, overflow, underflow
    );
endinterface

// File: rtl/counter_next_value.sv
// rtl/counter_next_value.sv - combinational next-count and overflow/underflow strobes
//
// Ports:
//   i_count     : current count
//   i_step      : unsigned step magnitude
//   i_direction : DIR_UP or DIR_DOWN
//   o_next      : count after applying the step
//   o_overflow  : up-step crossed MAX_COUNT
//   o_underflow : down-step crossed 0
module counter_next_value
    import counter_pkg::*;
#(
    parameter int            WIDTH      = 6,
    parameter int            STEP_WIDTH = 1,
    parameter int            MAX_COUNT  = (1 << WIDTH) - 1,
    parameter counter_mode_e MODE       = COUNT_WRAP
) (
    input  logic [WIDTH-1:0]      i_count,
    input  logic [STEP_WIDTH-1:0] i_step,
    input  count_dir_e            i_direction,
    output logic [WIDTH-1:0]      o_next,
    output logic                  o_overflow,
    output logic                  o_underflow
);
    // One extra bit so the sum and the wrapped difference never lose a carry.
    localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX_COUNT);
    localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MAX_COUNT + 1);

    logic [WIDTH:0] w_count_ext;
    logic [WIDTH:0] w_step_ext;
    logic [WIDTH:0] w_sum;

    assign w_count_ext = {1'b0, i_count};
    assign w_step_ext  = (WIDTH+1)'(i_step);
    assign w_sum       = w_count_ext + w_step_ext;

    always_comb begin
        o_next      = i_count;
        o_overflow  = 1'b0;
        o_underflow = 1'b0;
        if (i_direction == DIR_UP) begin
            if (w_sum > MAX_EXT) begin
                o_overflow = 1'b1;
                o_next     = (MODE == COUNT_WRAP) ? WIDTH'(w_sum - MOD_EXT)
                                                  : WIDTH'(MAX_EXT);
            end else begin
                o_next = WIDTH'(w_sum);
            end
        end else begin
            if (w_step_ext > w_count_ext) begin
                o_underflow = 1'b1;
                // Add the modulus before subtracting so the result stays non-negative.
                o_next      = (MODE == COUNT_WRAP) ? WIDTH'(w_count_ext + MOD_EXT - w_step_ext)
                                                   : '0;
            end else begin
                o_next = WIDTH'(w_count_ext - w_step_ext);
            end
        end
    end
endmodule

// File: rtl/updown_step_counter.sv
// rtl/updown_step_counter.sv - up/down counter with modulus, step, wrap/saturate and pulses
//
// Ports:
//   clock : core clock, rising edge
//   reset : asynchronous reset, active-high
//   bus   : updown_step_counter_if.slave (controls in, count/decodes/pulses out)
module updown_step_counter
    import counter_pkg::*;
#(
    parameter int            WIDTH      = 6,
    parameter int            MAX_COUNT  = (1 << WIDTH) - 1,
    parameter int            STEP_WIDTH = 1,
    parameter counter_mode_e MODE       = COUNT_WRAP
) (
    input logic                  clock,
    input logic                  reset,
    updown_step_counter_if.slave bus
);
    if (WIDTH < 1 || WIDTH > 30) begin : g_bad_width
        $fatal(1, "updown_step_counter: WIDTH must be 1..30");
    end
    if (MAX_COUNT < 1 || MAX_COUNT > (1 << WIDTH) - 1) begin : g_bad_max
        $fatal(1, "updown_step_counter: MAX_COUNT must be 1..2**WIDTH-1");
    end
    if (STEP_WIDTH < 1 || ((1 << STEP_WIDTH) - 1) > MAX_COUNT + 1) begin : g_bad_step
        $fatal(1, "updown_step_counter: largest step exceeds the modulus");
    end

    logic [WIDTH-1:0] r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic [WIDTH-1:0] w_next;
    logic             w_ovf;
    logic             w_unf;
    logic             w_step_req;
    count_dir_e       w_dir;

    // Conflicting requests or a zero step leave the count alone.
    assign w_step_req = (bus.increment ^ bus.decrement) && (bus.step != '0);
    assign w_dir      = bus.decrement ? DIR_DOWN : DIR_UP;

    counter_next_value #(
        .WIDTH      (WIDTH),
        .STEP_WIDTH (STEP_WIDTH),
        .MAX_COUNT  (MAX_COUNT),
        .MODE       (MODE)
    ) u_next (
        .i_count     (r_count),
        .i_step      (bus.step),
        .i_direction (w_dir),
        .o_next      (w_next),
        .o_overflow  (w_ovf),
        .o_underflow (w_unf)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            if (bus.clear) begin
                r_count <= '0;
            end else if (bus.load) begin
                r_count <= WIDTH'(clamp_to_max(32'(bus.load_value), MAX_COUNT));
            end else if (w_step_req) begin
                r_count     <= w_next;
                r_overflow  <= w_ovf;
                r_underflow <= w_unf;
            end
        end
    end

    assign bus.count     = r_count;
    assign bus.is_zero   = (r_count == '0);
    assign bus.is_max    = (r_count == WIDTH'(MAX_COUNT));
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
endmodule

// File: tb/tb_updown_step_counter.sv
// tb/tb_updown_step_counter.sv - self-checking bench for wrap and saturate counters
module tb_updown_step_counter;
    import counter_pkg::*;

    localparam int MAXC = 9;
    localparam int MODN = MAXC + 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic       clr = 0, ld = 0, inc = 0, dec = 0;
    logic [3:0] lv  = 0;
    logic [1:0] stp = 0;

    int  checks = 0;
    int  errors = 0;
    bit  running = 1'b1;

    updown_step_counter_if #(.WIDTH(4), .STEP_WIDTH(2)) bw ();
    updown_step_counter_if #(.WIDTH(4), .STEP_WIDTH(2)) bs ();

    assign bw.clear = clr;  assign bw.load = ld;  assign bw.load_value = lv;
    assign bw.increment = inc;  assign bw.decrement = dec;  assign bw.step = stp;
    assign bs.clear = clr;  assign bs.load = ld;  assign bs.load_value = lv;
    assign bs.increment = inc;  assign bs.decrement = dec;  assign bs.step = stp;

    updown_step_counter #(.WIDTH(4), .MAX_COUNT(9), .STEP_WIDTH(2), .MODE(COUNT_WRAP)) dut_wrap (
        .clock (clock), .reset (reset), .bus (bw)
    );
    updown_step_counter #(.WIDTH(4), .MAX_COUNT(9), .STEP_WIDTH(2), .MODE(COUNT_SATURATE)) dut_sat (
        .clock (clock), .reset (reset), .bus (bs)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: index 0 is modulo arithmetic, index 1 clamps at 0 and MAXC.
    int m_cnt[2];
    int m_ovf[2];
    int m_unf[2];

    always @(posedge clock or posedge reset) begin
        int s;
        int d;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_cnt[k] <= 0; m_ovf[k] <= 0; m_unf[k] <= 0;
            end else begin
                m_ovf[k] <= 0; m_unf[k] <= 0;
                if (clr) m_cnt[k] <= 0;
                else if (ld) m_cnt[k] <= (int'(lv) > MAXC) ? MAXC : int'(lv);
                else if (inc != dec && stp != 0) begin
                    if (inc) begin
                        s = m_cnt[k] + int'(stp);
                        m_ovf[k] <= (s > MAXC) ? 1 : 0;
                        m_cnt[k] <= (k == 0) ? s % MODN : ((s > MAXC) ? MAXC : s);
                    end else begin
                        d = m_cnt[k] - int'(stp);
                        m_unf[k] <= (d < 0) ? 1 : 0;
                        m_cnt[k] <= (k == 0) ? (d + MODN) % MODN : ((d < 0) ? 0 : d);
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        if (running && !reset) begin
            check("wrap count",    32'(bw.count),     m_cnt[0]);
            check("wrap overflow", 32'(bw.overflow),  m_ovf[0]);
            check("wrap underflow",32'(bw.underflow), m_unf[0]);
            check("wrap is_zero",  32'(bw.is_zero),   (m_cnt[0] == 0) ? 1 : 0);
            check("wrap is_max",   32'(bw.is_max),    (m_cnt[0] == MAXC) ? 1 : 0);
            check("sat count",     32'(bs.count),     m_cnt[1]);
            check("sat overflow",  32'(bs.overflow),  m_ovf[1]);
            check("sat underflow", 32'(bs.underflow), m_unf[1]);
            check("sat is_zero",   32'(bs.is_zero),   (m_cnt[1] == 0) ? 1 : 0);
            check("sat is_max",    32'(bs.is_max),    (m_cnt[1] == MAXC) ? 1 : 0);
            check("wrap in range", 32'(bw.count <= 4'd9), 1);
        end
    end

    // Drive one request for a single edge, then return to idle; call at a negedge.
    task automatic apply(input bit c, input bit l, input int v, input bit i, input bit d, input int s);
        clr = c; ld = l; lv = 4'(v); inc = i; dec = d; stp = 2'(s);
        @(negedge clock);
        clr = 0; ld = 0; lv = 0; inc = 0; dec = 0; stp = 0;
    endtask

    task automatic expect_k(input string tag, input int k, input int cnt, input int ov, input int un);
        if (k == 0) begin
            check({tag, " count"}, 32'(bw.count), cnt);
            check({tag, " overflow"}, 32'(bw.overflow), ov);
            check({tag, " underflow"}, 32'(bw.underflow), un);
            check({tag, " is_zero"}, 32'(bw.is_zero), (cnt == 0) ? 1 : 0);
            check({tag, " is_max"}, 32'(bw.is_max), (cnt == 9) ? 1 : 0);
        end else begin
            check({tag, " count"}, 32'(bs.count), cnt);
            check({tag, " overflow"}, 32'(bs.overflow), ov);
            check({tag, " underflow"}, 32'(bs.underflow), un);
            check({tag, " is_zero"}, 32'(bs.is_zero), (cnt == 0) ? 1 : 0);
            check({tag, " is_max"}, 32'(bs.is_max), (cnt == 9) ? 1 : 0);
        end
    endtask

    initial begin
        #3;
        expect_k("reset wrap", 0, 0, 0, 0);
        expect_k("reset sat", 1, 0, 0, 0);
        @(negedge clock); @(negedge clock);
        reset = 0;

        // Asynchronous reset between edges at count 7
        apply(0, 1, 7, 0, 0, 0);
        expect_k("load7 wrap", 0, 7, 0, 0);
        #2 reset = 1;
        #1;
        expect_k("async rst wrap", 0, 0, 0, 0);
        expect_k("async rst sat", 1, 0, 0, 0);
        #1 reset = 0;
        @(negedge clock);

        // Up past the terminal value
        apply(0, 1, 8, 0, 0, 0);
        apply(0, 0, 0, 1, 0, 3);
        expect_k("up8+3 wrap", 0, 1, 1, 0);
        expect_k("up8+3 sat", 1, 9, 1, 0);
        apply(0, 0, 0, 1, 0, 1);
        expect_k("up+1 wrap", 0, 2, 0, 0);
        expect_k("up+1 at max sat", 1, 9, 1, 0);
        apply(0, 0, 0, 0, 0, 0);
        expect_k("idle wrap", 0, 2, 0, 0);
        expect_k("idle sat", 1, 9, 0, 0);

        // Down past zero
        apply(0, 1, 1, 0, 0, 0);
        apply(0, 0, 0, 0, 1, 2);
        expect_k("dn1-2 wrap", 0, 9, 0, 1);
        expect_k("dn1-2 sat", 1, 0, 0, 1);
        apply(0, 1, 1, 0, 0, 0);
        apply(0, 0, 0, 0, 1, 3);
        expect_k("dn1-3 wrap", 0, 8, 0, 1);
        expect_k("dn1-3 sat", 1, 0, 0, 1);
        apply(0, 0, 0, 0, 1, 1);
        expect_k("dn-1 wrap", 0, 7, 0, 0);
        expect_k("dn-1 at zero sat", 1, 0, 0, 1);

        // Hold cases
        apply(0, 1, 5, 0, 0, 0);
        apply(0, 0, 0, 1, 1, 3);
        expect_k("inc&dec wrap", 0, 5, 0, 0);
        expect_k("inc&dec sat", 1, 5, 0, 0);
        apply(0, 0, 0, 1, 0, 0);
        expect_k("step0 wrap", 0, 5, 0, 0);
        apply(0, 0, 0, 0, 1, 0);
        expect_k("step0 dn sat", 1, 5, 0, 0);

        // Load clamps and outranks increment; clear outranks load
        apply(0, 1, 14, 1, 0, 1);
        expect_k("load14 wrap", 0, 9, 0, 0);
        expect_k("load14 sat", 1, 9, 0, 0);
        apply(1, 1, 3, 0, 0, 0);
        expect_k("clear wrap", 0, 0, 0, 0);
        expect_k("clear sat", 1, 0, 0, 0);

        // Wrap exactly at the terminal value
        apply(0, 1, 9, 0, 0, 0);
        apply(0, 0, 0, 1, 0, 1);
        expect_k("max+1 wrap", 0, 0, 1, 0);
        expect_k("max+1 sat", 1, 9, 1, 0);

        // Mixed directed sequence, checked by the model only
        for (int i = 0; i < 30; i++) begin
            apply((i % 13) == 12, (i % 11) == 10, (i * 7) % 16,
                  (i % 3) != 1, (i % 3) != 0, i % 4);
        end
        apply(0, 0, 0, 0, 0, 0);

        running = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
